// File: rtl/fetch_unit_pkg.sv
// Shared core package: fetch defaults, fetch FSM encoding, FIFO entry layout
// and the opcode constants used by decode and immediate generation.
package fetch_unit_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP              = 32'h0000_0013;

  // Fetch FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // One buffered fetch result handed to decode
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

  // Force a byte address onto a word boundary
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return a & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO between fetch and decode.
// Shift-register organisation: slot 0 is always the head, and every slot at or
// beyond the fill level is kept at zero so the head reads 0 when empty.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   i_push      write i_din (ignored during flush)
//   i_pop       remove head (ignored when empty or during flush)
//   i_flush     discard all entries; overrides push and pop
//   i_din       entry to write
//   o_head      head entry (0 when empty)
//   o_valid     FIFO non-empty
//   o_count     number of entries held
module fetch_fifo #(
  parameter  int unsigned DEPTH = 2,
  parameter  int unsigned WIDTH = 64,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_head,
  output logic             o_valid,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] r_mem  [DEPTH];
  logic [WIDTH-1:0] w_next [DEPTH];
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic [CNT_W-1:0] w_wr_idx;
  logic             r_valid;
  logic             w_push;
  logic             w_pop;

  assign w_push   = i_push && !i_flush;
  assign w_pop    = i_pop && (r_count != '0) && !i_flush;
  // A simultaneous pop shifts everything down one slot before the write lands
  assign w_wr_idx = w_pop ? (r_count - CNT_W'(1)) : r_count;

  // Next storage contents: shift on pop, then write at the fill level
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_next[i] = r_mem[i];
    end
    if (w_pop) begin
      for (int unsigned i = 0; i < DEPTH - 1; i++) begin
        w_next[i] = r_mem[i+1];
      end
      w_next[DEPTH-1] = '0;
    end
    if (w_push) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (w_wr_idx == CNT_W'(i)) begin
          w_next[i] = i_din;
        end
      end
    end
  end

  assign w_count_nxt = i_flush ? '0 : (r_count + CNT_W'(w_push) - CNT_W'(w_pop));

  // Storage and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_valid <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_count <= w_count_nxt;
      r_valid <= (w_count_nxt != '0);
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= i_flush ? '0 : w_next[i];
      end
    end
  end

  assign o_head  = r_mem[0];
  assign o_valid = r_valid;
  assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues single-word reads to
// instruction memory (one outstanding at a time, variable latency) and buffers
// returned {pc, instr} pairs toward decode. A redirect flushes the buffer and
// marks any in-flight read to be discarded.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   imem_req         one-cycle read request pulse
//   imem_addr        word address of the latest request, held between requests
//   imem_rvalid      read response strobe (one per request)
//   imem_rdata       read response data
//   redirect_valid   branch/jump taken this cycle
//   redirect_pc      redirect target (low two bits ignored)
//   if_valid         decode-side entry available
//   if_pc, if_instr  head entry (0 when empty)
//   id_ready         decode consumes the head this cycle
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        id_ready
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  fetch_state_e     r_state;
  fetch_state_e     w_state_nxt;
  logic [31:0]      r_pc;
  logic [31:0]      w_pc_nxt;
  logic             r_req;
  logic             w_req_nxt;
  logic [31:0]      r_addr;
  logic [31:0]      w_addr_nxt;
  logic             w_push;
  logic             w_pop;
  logic             w_flush;
  logic             w_fifo_valid;
  logic [CNT_W-1:0] w_fifo_count;
  fetch_entry_t     w_push_entry;
  fetch_entry_t     w_head;

  // State, PC and memory-interface registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_pc    <= RESET_PC;
      r_req   <= 1'b0;
      r_addr  <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_req   <= w_req_nxt;
      r_addr  <= w_addr_nxt;
    end
  end

  // Next-state, issue and push decisions; redirect takes priority over all
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_req_nxt   = 1'b0;
    w_addr_nxt  = r_addr;
    w_push      = 1'b0;
    w_flush     = 1'b0;

    if (redirect_valid) begin
      w_flush  = 1'b1;
      w_pc_nxt = word_align(redirect_pc);
      case (r_state)
        // An in-flight read must still be waited out, but its data is dead;
        // if it returns this very cycle there is nothing left to wait for.
        ST_WAIT, ST_DROP: w_state_nxt = imem_rvalid ? ST_IDLE : ST_DROP;
        default:          w_state_nxt = ST_IDLE;
      endcase
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_fifo_count < CNT_W'(FIFO_DEPTH)) begin
            w_req_nxt   = 1'b1;
            w_addr_nxt  = r_pc;
            w_pc_nxt    = r_pc + 32'd4;
            w_state_nxt = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            w_push      = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
        ST_DROP: begin
          if (imem_rvalid) begin
            w_state_nxt = ST_IDLE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // imem_addr still names the outstanding request when its data returns
  assign w_push_entry.pc    = r_addr;
  assign w_push_entry.instr = imem_rdata;

  assign w_pop = w_fifo_valid && id_ready;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_din   (w_push_entry),
    .o_head  (w_head),
    .o_valid (w_fifo_valid),
    .o_count (w_fifo_count)
  );

  assign imem_req  = r_req;
  assign imem_addr = r_addr;
  assign if_valid  = w_fifo_valid;
  assign if_pc     = w_head.pc;
  assign if_instr  = w_head.instr;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: variable-latency memory responder, directed scenarios
// and a randomized phase, checked by a queue-based reference model.
`timescale 1ns/1ps
module tb_fetch_unit;

  localparam int unsigned DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata  = '0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        id_ready;

  int n_vec = 0;
  int n_err = 0;
  int n_pop = 0;

  // memory responder control
  int          lat      = 1;
  bit          rand_lat = 1'b0;
  int          rsp_cnt  = 0;
  logic [31:0] rsp_addr = '0;

  // reference model state (monitor only)
  ent_t        exp_q[$];
  bit          outstanding = 1'b0;
  bit          keep        = 1'b0;
  logic [31:0] exp_pc      = RST_PC;
  logic [31:0] last_addr   = RST_PC;
  logic        exp_req     = 1'b0;

  fetch_unit #(
    .RESET_PC   (RST_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .id_ready       (id_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0000) return 32'h0000_0013;
    if (a == 32'h0000_0004) return 32'h0050_0093;
    return {a[15:0] ^ 16'hC3A5, a[31:16]} ^ 32'h0000_0003;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory: one response per request, 'lat' cycles after the request is seen
  always @(posedge clk) begin
    #1;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (rsp_cnt != 0) begin
      rsp_cnt--;
      if (rsp_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(rsp_addr);
      end
    end
    if (imem_req === 1'b1) begin
      rsp_cnt  = rand_lat ? int'($urandom_range(1, 4)) : lat;
      rsp_addr = imem_addr;
    end
  end

  // Monitor: compares outputs with the model, then applies the upcoming edge
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      outstanding = 1'b0;
      keep        = 1'b0;
      exp_pc      = RST_PC;
      last_addr   = RST_PC;
      exp_req     = 1'b0;
    end else begin
      chk("imem_req", 32'(imem_req), 32'(exp_req));
      if (imem_req) begin
        chk("req addr", imem_addr, exp_pc);
        last_addr   = exp_pc;
        exp_pc      = exp_pc + 32'd4;
        outstanding = 1'b1;
        keep        = 1'b1;
      end else begin
        chk("addr hold", imem_addr, last_addr);
      end

      chk("if_valid", 32'(if_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        chk("if_pc", if_pc, exp_q[0].pc);
        chk("if_instr", if_instr, exp_q[0].instr);
      end else begin
        chk("if_pc empty", if_pc, 32'h0);
        chk("if_instr empty", if_instr, 32'h0);
      end

      exp_req = !outstanding && !redirect_valid && (exp_q.size() < DEPTH);

      if (redirect_valid) begin
        exp_q.delete();
        exp_pc = {redirect_pc[31:2], 2'b00};
        keep   = 1'b0;
      end else if (if_valid && id_ready && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        n_pop++;
      end

      if (imem_rvalid && outstanding) begin
        if (keep && !redirect_valid) begin
          exp_q.push_back('{pc: last_addr, instr: imem_rdata});
        end
        outstanding = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic wait_req_chk(input string name, input logic [31:0] addr);
    bit found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (imem_req) found = 1'b1;
    end
    if (!found) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: no imem_req within 20 cycles, required addr %h", name, addr);
    end else begin
      chk(name, imem_addr, addr);
    end
  endtask

  task automatic wait_head(input string name, input logic [31:0] pc);
    bit found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      if (if_valid && if_pc == pc) found = 1'b1;
    end
    n_vec++;
    if (!found) begin
      n_err++;
      $display("FAIL %s: head pc %h not seen, last if_pc %h", name, pc, if_pc);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int pop0;
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    id_ready       = 1'b1;

    // 1: straight-line fetch, 1-cycle memory
    lat = 1;
    do_reset();
    chk("t1 rst if_valid", 32'(if_valid), 32'h0);
    step();
    chk("t1 first req", 32'(imem_req), 32'h1);
    chk("t1 first addr", imem_addr, RST_PC);
    wait_head("t1 head0", 32'h0);
    chk("t1 instr0", if_instr, 32'h0000_0013);
    wait_head("t1 head4", 32'h4);
    chk("t1 instr4", if_instr, 32'h0050_0093);

    // 2: decode stalled, FIFO fills and fetch stops
    id_ready = 1'b0;
    do_reset();
    repeat (12) step();
    chk("t2 stall req", 32'(imem_req), 32'h0);
    chk("t2 full head", if_pc, 32'h0);
    id_ready = 1'b1;
    step();
    chk("t2 second head", if_pc, 32'h4);
    wait_req_chk("t2 resume addr", 32'h8);

    // 3: redirect while a slow read is in flight
    lat = 3;
    do_reset();
    wait_req_chk("t3 a0", 32'h0);
    wait_req_chk("t3 a4", 32'h4);
    wait_req_chk("t3 a8", 32'h8);
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    step();
    redirect_valid = 1'b0;
    chk("t3 flushed", 32'(if_valid), 32'h0);
    wait_req_chk("t3 redirect addr", 32'h0000_0100);
    wait_head("t3 head", 32'h0000_0100);

    // 4: redirect coincident with a response, one entry buffered
    lat      = 1;
    id_ready = 1'b0;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      if (imem_rvalid && if_valid) begin
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        found          = 1'b1;
      end
    end
    n_vec++;
    if (!found) begin
      n_err++;
      $display("FAIL t4 setup: got no rvalid with one entry buffered, expected one within 30 cycles");
    end
    step();
    redirect_valid = 1'b0;
    chk("t4 flushed", 32'(if_valid), 32'h0);
    wait_req_chk("t4 redirect addr", 32'h0000_0200);

    // 5: unaligned redirect target
    id_ready = 1'b1;
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    step();
    redirect_valid = 1'b0;
    wait_req_chk("t5 aligned addr", 32'h0000_0100);

    // 6: reset mid-read, stale response after release
    lat      = 3;
    id_ready = 1'b0;
    do_reset();
    wait_req_chk("t6 a0", 32'h0);
    wait_req_chk("t6 a4", 32'h4);
    rst_n = 1'b0;
    #1;
    chk("t6 async req", 32'(imem_req), 32'h0);
    chk("t6 async valid", 32'(if_valid), 32'h0);
    chk("t6 async pc", if_pc, 32'h0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    step();
    chk("t6 stale ignored", 32'(if_valid), 32'h0);
    chk("t6 restart req", 32'(imem_req), 32'h1);
    chk("t6 restart addr", imem_addr, RST_PC);

    // 7: randomized traffic
    id_ready = 1'b1;
    rand_lat = 1'b1;
    repeat (4) step();
    pop0 = n_pop;
    for (int i = 0; i < 1500; i++) begin
      id_ready       = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 24) == 0);
      case ($urandom_range(0, 3))
        0:       redirect_pc = $urandom;
        1:       redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: redirect_pc = 32'($urandom_range(0, 255)) << 2;
      endcase
      step();
    end
    redirect_valid = 1'b0;
    id_ready       = 1'b1;
    repeat (40) step();
    chk("random pops", 32'((n_pop - pop0) > 100), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
